// File: rtl/branch_pkg.sv
// Shared constants for branch resolution and BTB counter handling.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RST = CTR_WNT;

    // Saturating 2-bit direction counter step.
    function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
        ctr_e n;
        n = c;
        case (c)
            CTR_SNT: n = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: n = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  n = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  n = taken ? CTR_ST  : CTR_WT;
            default: n = CTR_RST;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB storage: two combinational read ports (fetch, resolve),
// one synchronous write port, synchronous reset to a fixed entry value.
module branch_target_buffer #(
    parameter int                  ENTRIES   = 64,
    parameter int                  IDX_W     = $clog2(ENTRIES),
    parameter int                  ENTRY_W   = 1,
    parameter logic [ENTRY_W-1:0]  RST_ENTRY = '0
) (
    input  logic               gclk,
    input  logic               rst,
    input  logic [IDX_W-1:0]   rd_idx_a,
    output logic [ENTRY_W-1:0] rd_entry_a,
    input  logic [IDX_W-1:0]   rd_idx_b,
    output logic [ENTRY_W-1:0] rd_entry_b,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [ENTRY_W-1:0] wr_entry
);

    logic [ENTRY_W-1:0] mem [ENTRIES];

    always_ff @(posedge gclk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) mem[i] <= RST_ENTRY;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    // Reads see the pre-write contents: no write-to-read bypass.
    assign rd_entry_a = mem[rd_idx_a];
    assign rd_entry_b = mem[rd_idx_b];

endmodule

// File: rtl/branch_predict_resolve_unit.sv
// EX-stage branch resolve plus BTB-based fetch prediction and training.
// Optional BRANCH_PERF_COUNTERS_EN adds trained-branch / mispredict counters.
module branch_predict_resolve_unit
    import branch_pkg::*;
#(
    parameter int   XLEN        = 32,
    parameter int   BTB_ENTRIES = 64,
    localparam int  IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [XLEN-1:0] IF_PC,
    output logic            PRED_TAKEN,
    output logic [XLEN-1:0] PRED_TARGET,
    input  logic            EX_VALID,
    input  logic [XLEN-1:0] EX_PC,
    input  logic            EX_PRED_TAKEN,
    input  logic [XLEN-1:0] EX_PRED_TARGET,
    input  logic            JUMP,
    input  logic            BRANCH,
    input  logic [2:0]      FUNC3,
    input  logic [XLEN-1:0] OUT1,
    input  logic [XLEN-1:0] OUT2,
    input  logic [XLEN-1:0] ALU_RESULT,
    output logic            ACTUAL_TAKEN,
    output logic            MISPREDICT,
    output logic [XLEN-1:0] REDIRECT_PC
`ifdef BRANCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]     BRANCH_COUNT,
    output logic [31:0]     MISPREDICT_COUNT
`endif
);

    localparam int TAG_W = XLEN - IDX_W - 2;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [XLEN-1:0]   target;
        ctr_e              ctr;
        logic              is_jump;
    } btb_entry_t;

    localparam int ENTRY_W = $bits(btb_entry_t);
    localparam btb_entry_t RST_ENTRY = '{valid: 1'b0, tag: '0, target: '0,
                                         ctr: CTR_RST, is_jump: 1'b0};

    logic [ENTRY_W-1:0] if_raw, ex_raw;
    btb_entry_t         if_entry, ex_entry, wr_entry;
    logic               wr_en;

    branch_target_buffer #(
        .ENTRIES   (BTB_ENTRIES),
        .IDX_W     (IDX_W),
        .ENTRY_W   (ENTRY_W),
        .RST_ENTRY (RST_ENTRY)
    ) u_btb (
        .gclk       (CLK),
        .rst        (RESET),
        .rd_idx_a   (IF_PC[IDX_W+1:2]),
        .rd_entry_a (if_raw),
        .rd_idx_b   (EX_PC[IDX_W+1:2]),
        .rd_entry_b (ex_raw),
        .wr_en      (wr_en),
        .wr_idx     (EX_PC[IDX_W+1:2]),
        .wr_entry   (wr_entry)
    );

    assign if_entry = btb_entry_t'(if_raw);
    assign ex_entry = btb_entry_t'(ex_raw);

    logic unused_pc_lsbs;
    assign unused_pc_lsbs = &{1'b0, IF_PC[1:0], EX_PC[1:0]};

    // Fetch-side lookup; table contents are stale while RESET is held, so mask.
    logic if_hit;
    assign if_hit      = if_entry.valid && (if_entry.tag == IF_PC[XLEN-1:IDX_W+2]);
    assign PRED_TAKEN  = !RESET && if_hit && (if_entry.is_jump || if_entry.ctr[1]);
    assign PRED_TARGET = PRED_TAKEN ? if_entry.target : '0;

    logic br_legal, br_cond;
    always_comb begin
        br_legal = 1'b1;
        br_cond  = 1'b0;
        case (FUNC3)
            F3_BEQ:  br_cond = (OUT1 == OUT2);
            F3_BNE:  br_cond = (OUT1 != OUT2);
            F3_BLT:  br_cond = ($signed(OUT1) <  $signed(OUT2));
            F3_BGE:  br_cond = ($signed(OUT1) >= $signed(OUT2));
            F3_BLTU: br_cond = (OUT1 <  OUT2);
            F3_BGEU: br_cond = (OUT1 >= OUT2);
            default: br_legal = 1'b0;
        endcase
    end

    logic ex_live, train, ex_hit;
    assign ex_live      = EX_VALID && !RESET;
    assign ACTUAL_TAKEN = ex_live && (JUMP || (BRANCH && br_legal && br_cond));
    assign MISPREDICT   = ex_live && ((ACTUAL_TAKEN != EX_PRED_TAKEN) ||
                          (ACTUAL_TAKEN && (EX_PRED_TARGET != ALU_RESULT)));
    assign REDIRECT_PC  = ACTUAL_TAKEN ? ALU_RESULT : EX_PC + XLEN'(4);

    assign train  = ex_live && (JUMP || (BRANCH && br_legal));
    assign ex_hit = ex_entry.valid && (ex_entry.tag == EX_PC[XLEN-1:IDX_W+2]);

    // Hits always retrain the counter; misses only allocate when taken.
    always_comb begin
        wr_en    = 1'b0;
        wr_entry = ex_entry;
        if (train) begin
            if (ex_hit) begin
                wr_en        = 1'b1;
                wr_entry.ctr = ctr_next(ex_entry.ctr, ACTUAL_TAKEN);
                if (ACTUAL_TAKEN) begin
                    wr_entry.target  = ALU_RESULT;
                    wr_entry.is_jump = JUMP;
                end
            end else if (ACTUAL_TAKEN) begin
                wr_en    = 1'b1;
                wr_entry = '{valid: 1'b1, tag: EX_PC[XLEN-1:IDX_W+2],
                             target: ALU_RESULT, ctr: CTR_WT, is_jump: JUMP};
            end
        end
    end

`ifdef BRANCH_PERF_COUNTERS_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            BRANCH_COUNT     <= '0;
            MISPREDICT_COUNT <= '0;
        end else begin
            if (train)      BRANCH_COUNT     <= BRANCH_COUNT + 32'd1;
            if (MISPREDICT) MISPREDICT_COUNT <= MISPREDICT_COUNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_resolve_unit.sv
// Directed plus randomized bench for branch_predict_resolve_unit against a table-level model.
module tb_branch_predict_resolve_unit;

    localparam int XLEN = 32;
    localparam int N    = 64;
    localparam int IW   = 6;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] IF_PC;
    logic        PRED_TAKEN;
    logic [31:0] PRED_TARGET;
    logic        EX_VALID;
    logic [31:0] EX_PC;
    logic        EX_PRED_TAKEN;
    logic [31:0] EX_PRED_TARGET;
    logic        JUMP;
    logic        BRANCH;
    logic [2:0]  FUNC3;
    logic [31:0] OUT1, OUT2, ALU_RESULT;
    logic        ACTUAL_TAKEN;
    logic        MISPREDICT;
    logic [31:0] REDIRECT_PC;
`ifdef BRANCH_PERF_COUNTERS_EN
    logic [31:0] BRANCH_COUNT, MISPREDICT_COUNT;
`endif

    always #5 CLK = ~CLK;

    branch_predict_resolve_unit #(.XLEN(XLEN), .BTB_ENTRIES(N)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .IF_PC          (IF_PC),
        .PRED_TAKEN     (PRED_TAKEN),
        .PRED_TARGET    (PRED_TARGET),
        .EX_VALID       (EX_VALID),
        .EX_PC          (EX_PC),
        .EX_PRED_TAKEN  (EX_PRED_TAKEN),
        .EX_PRED_TARGET (EX_PRED_TARGET),
        .JUMP           (JUMP),
        .BRANCH         (BRANCH),
        .FUNC3          (FUNC3),
        .OUT1           (OUT1),
        .OUT2           (OUT2),
        .ALU_RESULT     (ALU_RESULT),
        .ACTUAL_TAKEN   (ACTUAL_TAKEN),
        .MISPREDICT     (MISPREDICT),
        .REDIRECT_PC    (REDIRECT_PC)
`ifdef BRANCH_PERF_COUNTERS_EN
        ,
        .BRANCH_COUNT     (BRANCH_COUNT),
        .MISPREDICT_COUNT (MISPREDICT_COUNT)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference table: one slot per index, counter as a plain 0..3 integer.
    bit          mv  [N];
    logic [31:0] mtag[N];
    logic [31:0] mtg [N];
    int          mc  [N];
    bit          mj  [N];
    int unsigned e_bc = 0;
    int unsigned e_mc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int mi(input logic [31:0] pc);
        return int'((pc >> 2) % 32'(N));
    endfunction

    function automatic bit mpred(input logic [31:0] pc);
        int i;
        i = mi(pc);
        return !RESET && mv[i] && (mtag[i] == (pc >> (IW + 2))) && (mj[i] || mc[i] >= 2);
    endfunction

    function automatic bit ref_taken();
        if (!EX_VALID || RESET) return 1'b0;
        if (JUMP) return 1'b1;
        if (!BRANCH) return 1'b0;
        case (FUNC3)
            3'd0: return OUT1 == OUT2;
            3'd1: return OUT1 != OUT2;
            3'd4: return $signed(OUT1) <  $signed(OUT2);
            3'd5: return $signed(OUT1) >= $signed(OUT2);
            3'd6: return OUT1 <  OUT2;
            3'd7: return OUT1 >= OUT2;
            default: return 1'b0;
        endcase
    endfunction

    task automatic cycle();
        bit          ph, tk, mp, hit;
        logic [31:0] rd;
        int          k;
        #2;
        ph = mpred(IF_PC);
        check("pred_taken", PRED_TAKEN, ph);
        check("pred_target", PRED_TARGET, ph ? mtg[mi(IF_PC)] : 32'h0);
        tk = ref_taken();
        mp = EX_VALID && !RESET && ((tk != EX_PRED_TAKEN) || (tk && EX_PRED_TARGET != ALU_RESULT));
        rd = tk ? ALU_RESULT : EX_PC + 32'd4;
        check("actual_taken", ACTUAL_TAKEN, tk);
        check("mispredict", MISPREDICT, mp);
        check("redirect_pc", REDIRECT_PC, rd);
        @(posedge CLK);
        if (RESET) begin
            for (int j = 0; j < N; j++) begin
                mv[j] = 0; mtag[j] = 0; mtg[j] = 0; mc[j] = 1; mj[j] = 0;
            end
            e_bc = 0;
            e_mc = 0;
        end else begin
            if (mp) e_mc++;
            if (EX_VALID && (JUMP || (BRANCH && FUNC3 != 3'd2 && FUNC3 != 3'd3))) begin
                e_bc++;
                k   = mi(EX_PC);
                hit = mv[k] && (mtag[k] == (EX_PC >> (IW + 2)));
                if (hit) begin
                    mc[k] = tk ? ((mc[k] < 3) ? mc[k] + 1 : 3) : ((mc[k] > 0) ? mc[k] - 1 : 0);
                    if (tk) begin mtg[k] = ALU_RESULT; mj[k] = JUMP; end
                end else if (tk) begin
                    mv[k] = 1; mtag[k] = EX_PC >> (IW + 2); mtg[k] = ALU_RESULT; mc[k] = 2; mj[k] = JUMP;
                end
            end
        end
        #1;
`ifdef BRANCH_PERF_COUNTERS_EN
        check("branch_count", BRANCH_COUNT, e_bc);
        check("mispredict_count", MISPREDICT_COUNT, e_mc);
`endif
    endtask

    task automatic ex(input bit v, input logic [31:0] pc, input bit pt, input logic [31:0] ptg,
                      input bit j, input bit b, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] bb, input logic [31:0] alu);
        EX_VALID = v; EX_PC = pc; EX_PRED_TAKEN = pt; EX_PRED_TARGET = ptg;
        JUMP = j; BRANCH = b; FUNC3 = f3; OUT1 = a; OUT2 = bb; ALU_RESULT = alu;
    endtask

    task automatic idle(input logic [31:0] ifpc);
        IF_PC = ifpc;
        ex(0, 32'h0, 0, 32'h0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0);
    endtask

    logic [31:0] pcs  [8] = '{32'h100, 32'h200, 32'h300, 32'h104, 32'h140, 32'h400, 32'hFFFF_FFFC, 32'h1100};
    logic [31:0] opnd [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    initial begin
        RESET = 1'b1;
        idle(32'h100);
        cycle();
        cycle();
        RESET = 1'b0;

        // Cold lookup, then a taken BEQ allocates.
        idle(32'h100);
        #1 check("cold_miss", PRED_TAKEN, 1'b0);
        cycle();
        ex(1, 32'h100, 0, 32'h0, 0, 1, 3'd0, 32'd5, 32'd5, 32'h180);
        #1 check("beq_mis", MISPREDICT, 1'b1);
        check("beq_redir", REDIRECT_PC, 32'h180);
        cycle();
        idle(32'h100);
        #1 check("alloc_pred", PRED_TAKEN, 1'b1);
        check("alloc_tgt", PRED_TARGET, 32'h180);
        cycle();

        // Saturate, then two not-taken outcomes.
        IF_PC = 32'h100;
        for (int i = 0; i < 3; i++) begin
            ex(1, 32'h100, 1, 32'h180, 0, 1, 3'd0, 32'd5, 32'd5, 32'h180);
            cycle();
        end
        ex(1, 32'h100, 1, 32'h180, 0, 1, 3'd0, 32'd5, 32'd6, 32'h180);
        #1 check("nt_mis", MISPREDICT, 1'b1);
        check("nt_redir", REDIRECT_PC, 32'h104);
        cycle();
        idle(32'h100);
        #1 check("wt_still_taken", PRED_TAKEN, 1'b1);
        cycle();
        ex(1, 32'h100, 1, 32'h180, 0, 1, 3'd0, 32'd5, 32'd6, 32'h180);
        cycle();
        idle(32'h100);
        #1 check("wnt_not_taken", PRED_TAKEN, 1'b0);
        cycle();

        // Signed vs unsigned compares.
        ex(1, 32'h140, 0, 32'h0, 0, 1, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h1C0);
        #1 check("blt_taken", ACTUAL_TAKEN, 1'b1);
        cycle();
        ex(1, 32'h140, 0, 32'h0, 0, 1, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h1C0);
        #1 check("bltu_not_taken", ACTUAL_TAKEN, 1'b0);
        cycle();

        // JALR target mispredict; 0x200 also aliases 0x100's slot.
        ex(1, 32'h200, 1, 32'h300, 1, 0, 3'd0, 32'h0, 32'h0, 32'h340);
        #1 check("jalr_mis", MISPREDICT, 1'b1);
        check("jalr_redir", REDIRECT_PC, 32'h340);
        cycle();
        idle(32'h200);
        #1 check("jalr_tgt", PRED_TARGET, 32'h340);
        cycle();
        idle(32'h100);
        #1 check("alias_miss", PRED_TAKEN, 1'b0);
        cycle();

        // Illegal FUNC3 with a stale taken prediction.
        ex(1, 32'h300, 1, 32'h380, 0, 1, 3'd2, 32'd1, 32'd1, 32'h380);
        #1 check("illegal_mis", MISPREDICT, 1'b1);
        check("illegal_redir", REDIRECT_PC, 32'h304);
        cycle();
        idle(32'h200);
        #1 check("illegal_no_update", PRED_TAKEN, 1'b1);
        cycle();

        // Reset during a taken BNE.
        RESET = 1'b1;
        ex(1, 32'h400, 0, 32'h0, 0, 1, 3'd1, 32'd1, 32'd2, 32'h480);
        #1 check("rst_mis", MISPREDICT, 1'b0);
        check("rst_taken", ACTUAL_TAKEN, 1'b0);
        cycle();
        RESET = 1'b0;
        idle(32'h400);
        #1 check("rst_no_alloc", PRED_TAKEN, 1'b0);
        cycle();
        idle(32'h200);
        #1 check("rst_cleared", PRED_TAKEN, 1'b0);
        cycle();

        // Ten branches, three mispredicted.
        for (int i = 0; i < 10; i++) begin
            IF_PC = 32'h500;
            if (i == 0)
                ex(1, 32'h500, 0, 32'h0, 0, 1, 3'd0, 32'd7, 32'd7, 32'h580);
            else
                ex(1, 32'h500, 1, (i == 4 || i == 7) ? 32'h999 : 32'h580, 0, 1, 3'd0, 32'd7, 32'd7, 32'h580);
            cycle();
        end
`ifdef BRANCH_PERF_COUNTERS_EN
        check("perf_branches", BRANCH_COUNT, 32'd10);
        check("perf_mispredicts", MISPREDICT_COUNT, 32'd3);
        RESET = 1'b1;
        idle(32'h0);
        cycle();
        RESET = 1'b0;
        check("perf_rst_b", BRANCH_COUNT, 32'd0);
        check("perf_rst_m", MISPREDICT_COUNT, 32'd0);
`endif

        // Random traffic over a small PC pool so entries hit, alias and retrain.
        for (int n = 0; n < 600; n++) begin
            int          r;
            logic [31:0] pc;
            RESET = ($urandom_range(0, 59) == 0);
            IF_PC = pcs[$urandom_range(0, 7)];
            pc    = pcs[$urandom_range(0, 7)];
            r     = $urandom_range(0, 9);
            EX_VALID = ($urandom_range(0, 4) != 0);
            EX_PC    = pc;
            JUMP     = (r < 2);
            BRANCH   = (r < 8) && (r >= 2 || $urandom_range(0, 1) == 1);
            FUNC3    = 3'($urandom_range(0, 7));
            OUT1     = ($urandom_range(0, 1) == 1) ? opnd[$urandom_range(0, 4)] : $urandom;
            OUT2     = ($urandom_range(0, 1) == 1) ? opnd[$urandom_range(0, 4)] : OUT1;
            ALU_RESULT = ($urandom_range(0, 2) == 0) ? {$urandom_range(0, 255), 2'b00} : pc + 32'h80;
            if ($urandom_range(0, 1) == 1) begin
                EX_PRED_TAKEN  = mpred(pc);
                EX_PRED_TARGET = EX_PRED_TAKEN ? mtg[mi(pc)] : 32'h0;
            end else begin
                EX_PRED_TAKEN  = 1'($urandom_range(0, 1));
                EX_PRED_TARGET = ($urandom_range(0, 1) == 1) ? ALU_RESULT : $urandom;
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
